sc_stream_decoder: RTL
======================

Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter that sits directly downstream of the APC neuron.
- Samples the neuron's serial `dout` bitstream, discards a programmable warm-up interval while the neuron's saturating state machine settles, then counts ones over a fixed window of 2^W valid bits.
- Presents the result as a binary value with a valid/ready handshake to the readout/host logic.

Parameters:
- W, 8, log2 of the accumulation window length; window = 2^W valid bits.
- SKIP, 4, number of valid bits discarded after start before accumulation begins; 0 allowed.
- VW, W+2, output value width; holds signed range ±2^W when bipolar mode is enabled.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-low.
- start  input  1  request one conversion; accepted only in IDLE, or in DONE on the cycle the handshake completes.
- bit_in  input  1  stochastic bit from neuron `dout`; neuron updates on negedge, so it is stable at posedge.
- bit_valid  input  1  qualifies bit_in; cycles with bit_valid=0 are ignored in every state.
- value  output  VW  conversion result; held stable while out_valid=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts value when out_valid & out_ready.
- busy  output  1  high in SKIP, ACCUM and DONE.
- overrun  output  1  one-cycle pulse when start is asserted but not accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE; value=0; out_valid=0; busy=0; overrun=0; skip_cnt=0; bit_cnt=0; ones_cnt=0. Reset mid-operation aborts the conversion with no output.
- Counter widths:
  - skip_cnt: clog2(SKIP+1) bits, minimum 1.
  - bit_cnt: W+1 bits.
  - ones_cnt: W+1 bits; maximum 2^W, cannot wrap.
- IDLE:
  - start=1 → SKIP if SKIP>0, else ACCUM.
  - On leaving IDLE, bit_cnt and ones_cnt clear to 0.
  - The bit presented in the start cycle is not sampled.
- SKIP:
  - Each valid bit increments skip_cnt.
  - On the SKIP-th valid bit: skip_cnt←0, go to ACCUM.
  - bit_in is not counted.
- ACCUM:
  - Each valid bit: bit_cnt+=1, ones_cnt+=bit_in.
  - On the valid bit that makes bit_cnt=2^W, that bit is included in ones_cnt.
  - At that edge, value is loaded with the final count and out_valid is set in the same edge, so out_valid is visible the cycle after the last accepted bit.
  - Then go to DONE.
- Unipolar mode: value = ones, zero-extended to VW.
- DONE:
  - value and out_valid are held; bit_in is ignored.
  - out_valid & out_ready: out_valid←0.
    - If start=1 in the same cycle → SKIP/ACCUM with counters cleared (back-to-back conversion).
    - Otherwise → IDLE.
- overrun:
  - Pulses for one cycle when start=1 in SKIP or ACCUM, or in DONE without a completing handshake.
  - The start is dropped.
- busy = (state != IDLE).
- Simultaneous events:
  - bit_valid=0 on the window's final cycle delays completion until the next valid bit.
  - start in the same cycle as entry to DONE is an overrun.

Optional Feature:
- Macro: SC_DEC_BIPOLAR_EN.
- Defined: value = 2*ones − 2^W as VW-bit two's complement.
  - Range −2^W … +2^W.
  - Matches XNOR bipolar encoding in the neuron.
- Undefined: unipolar count as above; no subtractor synthesized.
- Timing and handshake are identical in both modes.

Test Plan (W=3, SKIP=2 unless noted):
1. Hold reset=0 for 3 cycles while toggling start and bit_valid → value=0, out_valid=0, busy=0, overrun=0 throughout; release reset → stays IDLE.
2. Start, then 10 consecutive valid bits of 1 → first 2 discarded; out_valid=1 one cycle after the 10th valid bit; value=8; busy=1 until the handshake completes.
3. Start, then bits 1,0,1,0,… with bit_valid=0 on every third cycle → window completes after 2+8 valid bits; value=4; invalid cycles do not advance counters.
4. Hold out_ready=0 after completion, pulse start → overrun=1 for one cycle, value held at 4. Then out_ready=1 and start=1 in the same cycle → out_valid falls and the new conversion starts; all-zero bits → value=0.
5. Assert reset=0 after 5 valid bits in ACCUM → immediate IDLE, counters zero; next full conversion of all-ones → value=8, unaffected by the aborted run.
6. With SC_DEC_BIPOLAR_EN defined and SKIP=0: all-zero window → value=−8 (5'b11000); all-ones → +8; alternating bits → 0.

Source files
------------

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
// Stochastic-to-binary converter for the APC neuron's serial output. After a
// start request it drops SKIP valid bits while the neuron settles, then counts
// ones over a window of 2^W valid bits. It presents the count on a
// valid/ready handshake.
//
// Optional feature, macro SC_DEC_BIPOLAR_EN:
//   undefined - value is the unipolar ones count, zero-extended to VW bits.
//   defined   - value is 2*ones - 2^W as a VW-bit two's complement number,
//               which matches the neuron's XNOR bipolar encoding.
// Timing and handshake are the same in both builds.
module sc_stream_decoder #(
  parameter int W    = 8,
  parameter int SKIP = 4,
  parameter int VW   = W + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic [VW-1:0] value,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          overrun
);

  // skip_cnt must have at least one bit, even when SKIP is zero.
  localparam int SKW = ($clog2(SKIP + 1) < 1) ? 1 : $clog2(SKIP + 1);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [W:0]     BIT_LAST  = (W + 1)'((1 << W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_ACCUM,
    S_DONE
  } state_t;

  // A conversion starts in SKIP. When there is nothing to discard, it goes
  // straight to ACCUM.
  localparam state_t FIRST_STATE = (SKIP > 0) ? S_SKIP : S_ACCUM;

  state_t          state_q, state_d;
  logic [SKW-1:0]  skip_cnt_q, skip_cnt_d;
  logic [W:0]      bit_cnt_q, bit_cnt_d;
  logic [W:0]      ones_cnt_q, ones_cnt_d;
  logic [VW-1:0]   value_q, value_d;
  logic            out_valid_q, out_valid_d;
  logic            overrun_q, overrun_d;
  logic [VW-1:0]   ones_ext;
  logic [VW-1:0]   result;

  // Convert the final ones count, including the last bit, into the output encoding.
  assign ones_ext = VW'(ones_cnt_d);
`ifdef SC_DEC_BIPOLAR_EN
  assign result = (ones_ext << 1) - (VW'(1) << W);
`else
  assign result = ones_ext;
`endif

  // Next-state logic: sequencing, counting and the handshake.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that does not assign it
    // holds its value instead of inferring a latch.
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    value_d     = value_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The bit present in the start cycle is not sampled.
        if (start) begin
          state_d    = FIRST_STATE;
          skip_cnt_d = '0;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
        end
      end

      S_SKIP: begin
        overrun_d = start;
        if (bit_valid) begin
          if (skip_cnt_q == SKIP_LAST) begin
            skip_cnt_d = '0;
            state_d    = S_ACCUM;
          end else begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
          end
        end
      end

      S_ACCUM: begin
        overrun_d = start;
        if (bit_valid) begin
          bit_cnt_d  = bit_cnt_q + (W + 1)'(1);
          ones_cnt_d = ones_cnt_q + (W + 1)'(bit_in);
          // The window's last bit is counted, and the result is visible on the next cycle.
          if (bit_cnt_q == BIT_LAST) begin
            value_d     = result;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // A start in the handshake cycle begins a new conversion at once.
          if (start) begin
            state_d    = FIRST_STATE;
            skip_cnt_d = '0;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          overrun_d = start;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      skip_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      ones_cnt_q  <= '0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments ensure every register samples its
      // pre-edge value, whatever order the statements appear in.
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign value     = value_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
